// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR datapath.
//   DATA_W   : operand width (sample and coefficient)
//   PROD_W   : full-precision product width
//   sample_t : signed operand type
//   prod_t   : signed product type
//   csa_sum / csa_carry : bitwise 3:2 compressor outputs over a full product row
package fir_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 2 * DATA_W;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    // Sum output of a row of full adders.
    function automatic prod_t csa_sum(input prod_t x, input prod_t y, input prod_t z);
        return x ^ y ^ z;
    endfunction

    // Carry output of a row of full adders, already moved to the next weight.
    function automatic prod_t csa_carry(input prod_t x, input prod_t y, input prod_t z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

endpackage

// File: rtl/booth_mul16.sv
// Combinational signed 16x16 -> 32 multiplier.
// Radix-4 modified Booth recoding of the coefficient, carry-save reduction of the
// partial products, and one final carry-propagate add.
//   multiplicand : sample operand (two's complement)
//   multiplier   : coefficient operand, Booth-recoded (two's complement)
//   product      : exact signed product
module booth_mul16
    import fir_pkg::*;
(
    input  logic signed [DATA_W-1:0] multiplicand,
    input  logic signed [DATA_W-1:0] multiplier,
    output logic signed [PROD_W-1:0] product
);

    // Digit count; one extra digit past DATA_W/2 so the recoder also covers the
    // sign-extended top of the multiplier (that digit always recodes to 0).
    localparam int NUM_PP = DATA_W / 2 + 1;

    // Multiplier with an implicit 0 below bit 0 and two sign bits above the MSB,
    // so every digit reads an aligned 3-bit window.
    logic [DATA_W+2:0] b_ext;
    prod_t             a_ext;
    prod_t             pp_rows [NUM_PP];
    logic [NUM_PP-1:0] neg_bits;
    prod_t             corr_row;

    assign b_ext = {multiplier[DATA_W-1], multiplier[DATA_W-1], multiplier, 1'b0};
    assign a_ext = {{DATA_W{multiplicand[DATA_W-1]}}, multiplicand};

    generate
        for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_pp
            logic [2:0] trip;
            logic       sel_one;
            logic       sel_two;
            logic       neg;
            prod_t      mag;

            assign trip    = b_ext[2*gi+2 : 2*gi];
            assign sel_one = trip[1] ^ trip[0];
            assign sel_two = (trip == 3'b011) || (trip == 3'b100);
            // Window 111 recodes to zero, so it must not request negation.
            assign neg     = trip[2] & ~(trip[1] & trip[0]);
            assign mag     = sel_two ? (a_ext << 1) : (sel_one ? a_ext : '0);

            // Negation is one's complement here; the +1 is deferred to corr_row
            // so no adder sits inside each partial-product generator.
            assign pp_rows[gi]  = (neg ? ~mag : mag) << (2 * gi);
            assign neg_bits[gi] = neg;
        end
    endgenerate

    // Two's-complement completion bits: a 1 at the LSB weight of each negated row.
    always_comb begin
        corr_row = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            corr_row[2*i] = neg_bits[i];
        end
    end

    // Carry-save tree: 10 rows -> 7 -> 5 -> 4 -> 3 -> 2.
    prod_t s0, c0, s1, c1, s2, c2;
    prod_t s3, c3, s4, c4;
    prod_t s5, c5;
    prod_t s6, c6;
    prod_t s7, c7;

    assign s0 = csa_sum  (pp_rows[0], pp_rows[1], pp_rows[2]);
    assign c0 = csa_carry(pp_rows[0], pp_rows[1], pp_rows[2]);
    assign s1 = csa_sum  (pp_rows[3], pp_rows[4], pp_rows[5]);
    assign c1 = csa_carry(pp_rows[3], pp_rows[4], pp_rows[5]);
    assign s2 = csa_sum  (pp_rows[6], pp_rows[7], pp_rows[8]);
    assign c2 = csa_carry(pp_rows[6], pp_rows[7], pp_rows[8]);

    assign s3 = csa_sum  (s0, c0, s1);
    assign c3 = csa_carry(s0, c0, s1);
    assign s4 = csa_sum  (c1, s2, c2);
    assign c4 = csa_carry(c1, s2, c2);

    assign s5 = csa_sum  (s3, c3, s4);
    assign c5 = csa_carry(s3, c3, s4);

    assign s6 = csa_sum  (s5, c5, c4);
    assign c6 = csa_carry(s5, c5, c4);

    assign s7 = csa_sum  (s6, c6, corr_row);
    assign c7 = csa_carry(s6, c6, corr_row);

    // Final carry-propagate add; all arithmetic is modulo 2^PROD_W, which is exact
    // because the true product always fits in PROD_W bits.
    assign product = s7 + c7;

endmodule

// File: rtl/multiplier.sv
// Registered signed multiplier for the FIR datapath: delay-line sample times
// current coefficient, one product per clock, latency 1.
//   clk            : rising-edge clock
//   rst            : asynchronous active-high reset, clears the product register
//   shift_out      : sample operand (two's complement)
//   wsp_data       : coefficient operand (two's complement)
//   mnozenie_wynik : registered product (two's complement)
module multiplier
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] shift_out,
    input  logic signed [DATA_W-1:0] wsp_data,
    output logic signed [PROD_W-1:0] mnozenie_wynik
);

    prod_t product_next;

    booth_mul16 u_booth (
        .multiplicand (shift_out),
        .multiplier   (wsp_data),
        .product      (product_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mnozenie_wynik <= '0;
        end else begin
            mnozenie_wynik <= product_next;
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed corners, streaming, reset
// behaviour and random operands against an arithmetic golden model.
module tb_multiplier;

    logic               clk;
    logic               rst;
    logic signed [15:0] shift_out;
    logic signed [15:0] wsp_data;
    logic signed [31:0] mnozenie_wynik;

    int vec_count  = 0;
    int miscompare = 0;

    // Products awaiting the edge that should present them.
    logic signed [31:0] exp_q [$];
    logic signed [31:0] last_exp;

    multiplier dut (
        .clk            (clk),
        .rst            (rst),
        .shift_out      (shift_out),
        .wsp_data       (wsp_data),
        .mnozenie_wynik (mnozenie_wynik)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: plain integer product of the two signed operands.
    function automatic logic signed [31:0] golden(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
        longint pa;
        longint pb;
        longint p;
        pa = a;
        pb = b;
        p  = pa * pb;
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miscompare++;
            $display("FAIL %s: got %h (%0d) expected %h (%0d)", tag, obs, obs, exp, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Wait for the next edge and compare against the oldest queued product.
    task automatic step_check(input string tag);
        logic signed [31:0] e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        last_exp = e;
        check(tag, mnozenie_wynik, e);
    endtask

    task automatic apply(input string tag, input logic signed [15:0] a,
                         input logic signed [15:0] b);
        shift_out = a;
        wsp_data  = b;
        exp_q.push_back(golden(a, b));
        step_check(tag);
    endtask

    initial begin
        rst       = 1'b0;
        shift_out = 16'sd1234;
        wsp_data  = -16'sd5;

        // Asynchronous assertion: output clears before any clock edge exists.
        #1 rst = 1'b1;
        #1 check("reset_async", mnozenie_wynik, 32'sd0);

        // Held reset overrides clock edges despite nonzero operands.
        repeat (2) @(posedge clk);
        #1 check("reset_held", mnozenie_wynik, 32'sd0);

        @(negedge clk);
        rst = 1'b0;
        apply("first_after_reset", 16'sd1234, -16'sd5);

        // Small positives.
        apply("5x3",      16'sd5,     16'sd3);
        apply("100x20",   16'sd100,   16'sd20);
        apply("30000x2",  16'sd30000, 16'sd2);

        // Signed corners.
        apply("m1xm1",        -16'sd1,     -16'sd1);
        apply("min_x_min",    -16'sd32768, -16'sd32768);
        apply("min_x_max",    -16'sd32768,  16'sd32767);
        apply("max_x_max",     16'sd32767,  16'sd32767);
        apply("7x0",           16'sd7,      16'sd0);
        apply("0xmin",         16'sd0,     -16'sd32768);
        apply("m3x7",         -16'sd3,      16'sd7);
        apply("max_x_m1",      16'sd32767, -16'sd1);

        // Constant-check of corner values from first principles.
        check("const_min_min", golden(-16'sd32768, -16'sd32768), 32'sh4000_0000);
        check("const_min_max", golden(-16'sd32768,  16'sd32767), 32'shC000_8000);

        // Operands changing mid-cycle must not disturb the registered product.
        shift_out = 16'sd111;
        wsp_data  = -16'sd222;
        #2 check("hold_between_edges", mnozenie_wynik, last_exp);

        // Back-to-back streaming, a new pair every cycle.
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("stream%0d", i), 16'(($urandom % 65536)), 16'(($urandom % 65536)));
        end

        // Reset pulse between two edges during streaming.
        apply("pre_pulse", 16'sd400, 16'sd9);
        #2 rst = 1'b1;
        #1 check("reset_pulse", mnozenie_wynik, 32'sd0);
        shift_out = -16'sd1500;
        wsp_data  = 16'sd21;
        exp_q.push_back(golden(-16'sd1500, 16'sd21));
        #1 rst = 1'b0;
        step_check("post_pulse");

        // Random operand pairs.
        for (int i = 0; i < 10000; i++) begin
            logic signed [15:0] ra;
            logic signed [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            // Bias some draws towards zero and the extreme values.
            case ($urandom_range(0, 15))
                0: ra = 16'sh8000;
                1: rb = 16'sh8000;
                2: ra = 16'sh7FFF;
                3: rb = 16'sd0;
                default: ;
            endcase
            apply($sformatf("rand%0d", i), ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule
